// File: rtl/bus_timer.sv
// bus_timer - memory-mapped down-counting timer for the Bridge peripheral port.
//
// The CPU programs reload value, prescaler and mode with word writes and polls
// the count and status with reads. Each prescaler tick decrements COUNT. When a
// tick finds COUNT at zero, the timer expires: it sets EXP (and OVR if EXP was
// still set), then either reloads from LOAD (AUTO=1) or stops (AUTO=0).
//
// Register map (byte offsets on addr[11:0]):
//   0x020 CTRL   bit0 EN, bit1 AUTO, bit2 IE (IE only with TIMER_IRQ_EN)
//   0x024 LOAD   reload value
//   0x028 COUNT  current count (read/write)
//   0x02C STATUS bit0 EXP, bit1 OVR, write-1-to-clear
//   0x030 PRESC  prescaler divisor; period is (LOAD+1)*(PRESC+1) cycles
//
// Ports:
//   clk    bus/CPU clock
//   rst    asynchronous active-low reset
//   addr   register offset, decoded on [11:0]
//   we     write strobe, sampled on rising clk
//   wdata  write data
//   rdata  combinational read data for addr (0 for unmapped offsets)
//   irq    registered level interrupt IE & EXP (only with TIMER_IRQ_EN)
//
// Build option: define TIMER_IRQ_EN to add the irq port and the CTRL.IE bit.

module bus_timer #(
    parameter int PRESCALE_W = 16,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
`ifdef TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [11:0] ADDR_CTRL   = 12'h020;
    localparam logic [11:0] ADDR_LOAD   = 12'h024;
    localparam logic [11:0] ADDR_COUNT  = 12'h028;
    localparam logic [11:0] ADDR_STATUS = 12'h02C;
    localparam logic [11:0] ADDR_PRESC  = 12'h030;

    logic                  en;
    logic                  auto_rl;
    logic                  ie;
    logic                  exp_flag;
    logic                  ovr;
    logic [CNT_W-1:0]      load;
    logic [CNT_W-1:0]      count;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] pcnt;

    logic wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    logic tick, zero, expire, start, en_nxt;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_load   = we && (addr == ADDR_LOAD);
    assign wr_count  = we && (addr == ADDR_COUNT);
    assign wr_status = we && (addr == ADDR_STATUS);
    assign wr_presc  = we && (addr == ADDR_PRESC);

    assign tick   = en && (pcnt == presc);
    assign zero   = (count == '0);
    assign expire = tick && zero;
    // Only a 0->1 EN edge restarts the count; rewriting EN=1 while running does not.
    assign start  = wr_ctrl && wdata[0] && !en;

    // A software CTRL write takes priority over a one-shot expiry stopping the timer.
    always_comb begin
        en_nxt = en;
        if (wr_ctrl)
            en_nxt = wdata[0];
        else if (expire && !auto_rl)
            en_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            exp_flag <= 1'b0;
            ovr      <= 1'b0;
            load     <= '0;
            count    <= '0;
            presc    <= '0;
            pcnt     <= '0;
        end else begin
            en <= en_nxt;
            if (wr_ctrl)
                auto_rl <= wdata[1];
            if (wr_load)
                load <= wdata[CNT_W-1:0];
            if (wr_presc)
                presc <= wdata[PRESCALE_W-1:0];

            // Prescaler restarts from zero after each tick, on enable, and while stopped.
            if (!en_nxt || start || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESCALE_W'(1);

            // A direct COUNT write overrides any same-cycle decrement or reload.
            if (wr_count)
                count <= wdata[CNT_W-1:0];
            else if (start)
                count <= load;
            else if (tick) begin
                if (!zero)
                    count <= count - CNT_W'(1);
                else if (auto_rl)
                    count <= load;
            end

            // A new expiry beats a same-cycle write-1-to-clear.
            if (expire)
                exp_flag <= 1'b1;
            else if (wr_status && wdata[0])
                exp_flag <= 1'b0;

            if (expire && exp_flag)
                ovr <= 1'b1;
            else if (wr_status && wdata[1])
                ovr <= 1'b0;
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl)
                ie <= wdata[2];
            irq <= ie && exp_flag;
        end
    end
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {29'd0, ie, auto_rl, en};
            ADDR_LOAD:   rdata = 32'(load);
            ADDR_COUNT:  rdata = 32'(count);
            ADDR_STATUS: rdata = {30'd0, ovr, exp_flag};
            ADDR_PRESC:  rdata = 32'(presc);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_timer.sv
// Testbench for bus_timer: directed scenarios with hand-derived expectations,
// then randomized register traffic compared against a behavioural model.
// Define TIMER_IRQ_EN to also exercise the interrupt output.

module tb_bus_timer;

    localparam logic [11:0] A_CTRL   = 12'h020;
    localparam logic [11:0] A_LOAD   = 12'h024;
    localparam logic [11:0] A_COUNT  = 12'h028;
    localparam logic [11:0] A_STATUS = 12'h02C;
    localparam logic [11:0] A_PRESC  = 12'h030;

`ifdef TIMER_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
    logic irq;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    bus_timer #(.PRESCALE_W(16), .CNT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata)
`ifdef TIMER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_en, m_auto, m_ie, m_exp, m_ovr, m_irq;
    longint      m_load, m_count;
    int          m_presc, m_pcnt;

    task automatic model_clear();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ovr = 0; m_irq = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
    endtask

    function automatic logic [31:0] model_read(logic [11:0] a);
        case (a)
            A_CTRL:   return {29'd0, m_ie, m_auto, m_en};
            A_LOAD:   return 32'(m_load);
            A_COUNT:  return 32'(m_count);
            A_STATUS: return {30'd0, m_ovr, m_exp};
            A_PRESC:  return 32'(m_presc);
            default:  return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the bus values presented this cycle.
    task automatic model_step();
        bit          w = we;
        logic [11:0] a = addr;
        logic [31:0] d = wdata;
        bit          tk, xp;
        bit          en, au, ie, e, o;
        longint      ld, c;
        int          ps, p;
        if (!rst) begin
            model_clear();
            return;
        end
        en = m_en; au = m_auto; ie = m_ie; e = m_exp; o = m_ovr;
        ld = m_load; c = m_count; ps = m_presc;
        tk = m_en && (m_pcnt == m_presc);
        xp = tk && (m_count == 0);
        if (tk) begin
            if (m_count != 0) c = m_count - 1;
            else begin
                e = 1;
                if (m_exp) o = 1;
                if (m_auto) c = m_load; else en = 0;
            end
        end
        if (w) begin
            case (a)
                A_CTRL: begin
                    if (!m_en && d[0]) c = m_load;
                    en = d[0]; au = d[1]; ie = HAS_IRQ && d[2];
                end
                A_LOAD:   ld = longint'(d);
                A_COUNT:  c = longint'(d);
                A_STATUS: begin
                    if (d[0] && !xp) e = 0;
                    if (d[1] && !(xp && m_exp)) o = 0;
                end
                A_PRESC:  ps = int'(d[15:0]);
                default: ;
            endcase
        end
        if (tk || !en || (!m_en && en)) p = 0;
        else p = (m_pcnt + 1) % 65536;
        m_irq = m_ie && m_exp;
        m_en = en; m_auto = au; m_ie = ie; m_exp = e; m_ovr = o;
        m_load = ld; m_count = c; m_presc = ps; m_pcnt = p;
    endtask

    task automatic set_bus(input bit w, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6] = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESC, 12'h100};
        rst = 0;
        model_clear();
        set_bus(0, A_CTRL, 0);
        repeat (3) clock_edge();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            set_bus(0, addrs[i], 0);
            n_cmp++;
            if (rdata !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_read[%h]: got %h expected 0", addrs[i], rdata);
            end
`ifdef TIMER_IRQ_EN
            n_cmp++;
            if (irq !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_irq: got %b expected 0", irq);
            end
`endif
            clock_edge();
        end
    endtask

    task automatic test_one_shot();
        set_bus(1, A_LOAD, 3);  clock_edge();
        set_bus(1, A_PRESC, 0); clock_edge();
        set_bus(1, A_CTRL, 1);  clock_edge();
        for (int i = 0; i < 4; i++) begin
            set_bus(0, A_COUNT, 0);
            n_cmp++;
            if (rdata !== 32'(3 - i)) begin
                n_bad++;
                $display("FAIL oneshot_count[%0d]: got %0d expected %0d", i, rdata, 3 - i);
            end
            clock_edge();
        end
        set_bus(0, A_STATUS, 0);
        n_cmp++;
        if (rdata !== 32'h1) begin
            n_bad++;
            $display("FAIL oneshot_status: got %h expected 1", rdata);
        end
        clock_edge();
        set_bus(0, A_CTRL, 0);
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL oneshot_ctrl_stopped: got %h expected 0", rdata);
        end
        clock_edge();
        set_bus(0, A_COUNT, 0);
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL oneshot_count_hold: got %0d expected 0", rdata);
        end
        clock_edge();
        set_bus(1, A_STATUS, 3); clock_edge();
    endtask

    task automatic test_auto_reload();
        int period;
        logic [31:0] want;
        set_bus(1, A_LOAD, 1);  clock_edge();
        set_bus(1, A_PRESC, 2); clock_edge();
        set_bus(1, A_CTRL, 3);  clock_edge();
        period = (1 + 1) * (2 + 1);
        for (int j = 0; j < 14; j++) begin
            set_bus(0, A_STATUS, 0);
            want = (j >= 2 * period) ? 32'h3 : (j >= period) ? 32'h1 : 32'h0;
            n_cmp++;
            if (rdata !== want) begin
                n_bad++;
                $display("FAIL auto_status[%0d]: got %h expected %h", j, rdata, want);
            end
            clock_edge();
        end
        set_bus(1, A_STATUS, 3); clock_edge();
        set_bus(0, A_STATUS, 0);
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL auto_status_cleared: got %h expected 0", rdata);
        end
        clock_edge();
        set_bus(1, A_CTRL, 0);   clock_edge();
        set_bus(1, A_STATUS, 3); clock_edge();
    endtask

    task automatic test_clear_collision();
        // One-shot LOAD=2, PRESC=0: expiry on the 3rd edge after enable
        set_bus(1, A_LOAD, 2);  clock_edge();
        set_bus(1, A_PRESC, 0); clock_edge();
        set_bus(1, A_CTRL, 1);  clock_edge();
        set_bus(0, A_COUNT, 0); clock_edge();
        set_bus(0, A_COUNT, 0); clock_edge();
        set_bus(1, A_STATUS, 1); clock_edge();
        set_bus(0, A_STATUS, 0);
        n_cmp++;
        if (rdata !== 32'h1) begin
            n_bad++;
            $display("FAIL collision_exp: got %h expected 1", rdata);
        end
        clock_edge();
        set_bus(1, A_STATUS, 3); clock_edge();
    endtask

    task automatic test_mid_run();
        set_bus(1, A_LOAD, 8);  clock_edge();
        set_bus(1, A_PRESC, 0); clock_edge();
        set_bus(1, A_CTRL, 3);  clock_edge();
        for (int j = 0; j < 3; j++) begin
            set_bus(0, A_COUNT, 0);
            n_cmp++;
            if (rdata !== 32'(8 - j)) begin
                n_bad++;
                $display("FAIL midrun_count[%0d]: got %0d expected %0d", j, rdata, 8 - j);
            end
            clock_edge();
        end
        set_bus(1, A_LOAD, 10);
        n_cmp++;
        if (rdata !== 32'd8) begin
            n_bad++;
            $display("FAIL midrun_old_load: got %0d expected 8", rdata);
        end
        clock_edge();
        for (int j = 4; j < 9; j++) begin
            set_bus(0, A_COUNT, 0);
            n_cmp++;
            if (rdata !== 32'(8 - j)) begin
                n_bad++;
                $display("FAIL midrun_continue[%0d]: got %0d expected %0d", j, rdata, 8 - j);
            end
            clock_edge();
        end
        set_bus(0, A_COUNT, 0);
        n_cmp++;
        if (rdata !== 32'd10) begin
            n_bad++;
            $display("FAIL midrun_reload: got %0d expected 10", rdata);
        end
        clock_edge();
        set_bus(1, A_COUNT, 7); clock_edge();
        set_bus(0, A_COUNT, 0);
        n_cmp++;
        if (rdata !== 32'd7) begin
            n_bad++;
            $display("FAIL midrun_count_write: got %0d expected 7", rdata);
        end
        clock_edge();
        set_bus(1, A_CTRL, 0);   clock_edge();
        set_bus(1, A_STATUS, 3); clock_edge();
    endtask

`ifdef TIMER_IRQ_EN
    task automatic test_irq();
        bit want_irq, want_exp;
        set_bus(1, A_LOAD, 0);  clock_edge();
        set_bus(1, A_PRESC, 3); clock_edge();
        set_bus(1, A_CTRL, 7);  clock_edge();
        for (int j = 0; j < 14; j++) begin
            want_irq = (j == 5 || j == 6 || j == 9 || j == 10);
            want_exp = (j == 4 || j == 5 || j >= 8);
            if (j == 5)      set_bus(1, A_STATUS, 1);
            else if (j == 9) set_bus(1, A_CTRL, 3);
            else begin
                set_bus(0, A_STATUS, 0);
                n_cmp++;
                if (rdata[0] !== want_exp) begin
                    n_bad++;
                    $display("FAIL irq_exp[%0d]: got %b expected %b", j, rdata[0], want_exp);
                end
            end
            n_cmp++;
            if (irq !== want_irq) begin
                n_bad++;
                $display("FAIL irq_level[%0d]: got %b expected %b", j, irq, want_irq);
            end
            clock_edge();
        end
        set_bus(1, A_CTRL, 0);   clock_edge();
        set_bus(1, A_STATUS, 3); clock_edge();
    endtask
`endif

    task automatic test_reset_mid();
        set_bus(1, A_LOAD, 20); clock_edge();
        set_bus(1, A_PRESC, 1); clock_edge();
        set_bus(1, A_CTRL, 7);  clock_edge();
        repeat (5) begin
            set_bus(0, A_COUNT, 0);
            clock_edge();
        end
        @(negedge clk);
        #2;
        rst = 0;
        model_clear();
        we = 0; addr = A_COUNT;
        #1;
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d expected 0", rdata);
        end
        repeat (2) clock_edge();
        @(negedge clk);
        rst = 1;
        for (int j = 0; j < 5; j++) begin
            set_bus(0, (j == 0) ? A_CTRL : A_COUNT, 0);
            n_cmp++;
            if (rdata !== 32'd0) begin
                n_bad++;
                $display("FAIL midreset_idle[%0d]: got %h expected 0", j, rdata);
            end
            clock_edge();
        end
    endtask

    task automatic test_random();
        logic [11:0] raddrs [9] = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESC,
                                    12'h034, 12'h01C, 12'h100, 12'hFFC};
        logic [31:0] want;
        logic [11:0] a;
        logic [31:0] d;
        bit          w;
        int          r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 11));
            w = 1'b1;
            case (r)
                0:  begin a = A_CTRL;   d = 32'($urandom_range(0, 7)); end
                1:  begin a = A_LOAD;   d = 32'($urandom_range(0, 6)); end
                2:  begin a = A_COUNT;  d = 32'($urandom_range(0, 6)); end
                3:  begin a = A_STATUS; d = 32'($urandom_range(0, 3)); end
                4:  begin a = A_PRESC;  d = 32'($urandom_range(0, 2)); end
                5:  begin a = 12'h100;  d = $urandom; end
                default: begin
                    w = 1'b0;
                    a = raddrs[$urandom_range(0, 8)];
                    d = $urandom;
                end
            endcase
            set_bus(w, a, d);
            want = model_read(a);
            n_cmp++;
            if (rdata !== want) begin
                n_bad++;
                $display("FAIL random_read[%0d] addr %h: got %h expected %h", i, a, rdata, want);
            end
`ifdef TIMER_IRQ_EN
            n_cmp++;
            if (irq !== m_irq) begin
                n_bad++;
                $display("FAIL random_irq[%0d]: got %b expected %b", i, irq, m_irq);
            end
`endif
            clock_edge();
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_clear_collision();
        test_mid_run();
`ifdef TIMER_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
